// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared mode constants and sizing/clamp helpers for calc_accum
package calc_pkg;

  localparam int SIGNED_OFF = 0;
  localparam int SIGNED_ON  = 1;
  localparam int SAT_WRAP   = 0;
  localparam int SAT_CLAMP  = 1;

  typedef enum logic [1:0] {
    OVF_NONE = 2'd0,
    OVF_HIGH = 2'd1,
    OVF_LOW  = 2'd2
  } ovf_dir_t;

  // One full product, log2 growth across the tree, plus a guard bit.
  function automatic int calc_sum_width(input int data_width, input int block_size);
    return 2 * data_width + $clog2(block_size) + 1;
  endfunction

  function automatic ovf_dir_t calc_ovf_dir(input logic above, input logic below);
    if (above) return OVF_HIGH;
    if (below) return OVF_LOW;
    return OVF_NONE;
  endfunction

endpackage

// File: rtl/calc_dot_tree.sv
// rtl/calc_dot_tree.sv - stage 1 product registers and the beat sum adder tree
module calc_dot_tree
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_SIZE  = 4,
  parameter int SIGNED_MODE = 0
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             advance,
  input  logic                                             in_valid,
  input  logic                                             in_last,
  input  logic [DATA_WIDTH*BLOCK_SIZE-1:0]                 a_vec,
  input  logic [DATA_WIDTH*BLOCK_SIZE-1:0]                 b_vec,
  output logic                                             s1_valid,
  output logic                                             s1_last,
  output logic [calc_sum_width(DATA_WIDTH, BLOCK_SIZE)-1:0] s1_sum
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = calc_sum_width(DATA_WIDTH, BLOCK_SIZE);

  logic [PROD_W-1:0] prod_d [BLOCK_SIZE];
  logic [PROD_W-1:0] prod_q [BLOCK_SIZE];

  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (SIGNED_MODE == SIGNED_ON)
        prod_d[i] = PROD_W'($signed(a_vec[i*DATA_WIDTH +: DATA_WIDTH]))
                  * PROD_W'($signed(b_vec[i*DATA_WIDTH +: DATA_WIDTH]));
      else
        prod_d[i] = PROD_W'(a_vec[i*DATA_WIDTH +: DATA_WIDTH])
                  * PROD_W'(b_vec[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Products only load on a real beat so bubbles leave them untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) prod_q[i] <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_last  <= in_valid & in_last;
      if (in_valid) begin
        for (int i = 0; i < BLOCK_SIZE; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  always_comb begin
    s1_sum = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (SIGNED_MODE == SIGNED_ON)
        s1_sum = s1_sum + SUM_W'($signed(prod_q[i]));
      else
        s1_sum = s1_sum + SUM_W'(prod_q[i]);
    end
  end

endmodule

// File: rtl/calc_accum.sv
// rtl/calc_accum.sv - two-stage pipelined block dot-product accumulator
module calc_accum
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_SIZE  = 4,
  parameter int ACC_WIDTH   = 32,
  parameter int SIGNED_MODE = 0,
  parameter int SATURATE    = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] a_vec,
  input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] b_vec,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ACC_WIDTH-1:0]            out_data,
  output logic                            out_overflow,
  output logic [CNT_WIDTH-1:0]            out_beats
);

  localparam int SUM_W = calc_sum_width(DATA_WIDTH, BLOCK_SIZE);
  localparam int EXT_W = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 2;

  logic                 stall;
  logic                 s1_valid;
  logic                 s1_last;
  logic [SUM_W-1:0]     s1_sum;

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 ovf_q;
  logic                 ovf_next;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_next;

  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] sum_ext;
  logic signed [EXT_W-1:0] total_ext;
  logic signed [EXT_W-1:0] lim_one;
  logic signed [EXT_W-1:0] max_ext;
  logic signed [EXT_W-1:0] min_ext;
  ovf_dir_t                ovf_dir;

  // A finished sum cannot leave stage 2 while the output register is still owned.
  assign stall    = out_valid && !out_ready && s1_valid && s1_last;
  assign in_ready = !stall && !reset;

  calc_dot_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE),
    .SIGNED_MODE(SIGNED_MODE)
  ) u_tree (
    .clock   (clock),
    .reset   (reset),
    .advance (!stall),
    .in_valid(in_valid),
    .in_last (in_last),
    .a_vec   (a_vec),
    .b_vec   (b_vec),
    .s1_valid(s1_valid),
    .s1_last (s1_last),
    .s1_sum  (s1_sum)
  );

  always_comb begin
    lim_one    = '0;
    lim_one[0] = 1'b1;
    if (SIGNED_MODE == SIGNED_ON) begin
      acc_ext = EXT_W'($signed(acc_q));
      sum_ext = EXT_W'($signed(s1_sum));
      max_ext = (lim_one <<< (ACC_WIDTH - 1)) - lim_one;
      min_ext = -(lim_one <<< (ACC_WIDTH - 1));
    end else begin
      acc_ext = $signed(EXT_W'(acc_q));
      sum_ext = $signed(EXT_W'(s1_sum));
      max_ext = (lim_one <<< ACC_WIDTH) - lim_one;
      min_ext = '0;
    end
    total_ext = acc_ext + sum_ext;
    ovf_dir   = calc_ovf_dir(total_ext > max_ext, total_ext < min_ext);
    ovf_next  = ovf_q || (ovf_dir != OVF_NONE);
    cnt_next  = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    acc_next  = total_ext[ACC_WIDTH-1:0];
    // Once clamped, the accumulator stays pinned until the packet ends.
    if (SATURATE == SAT_CLAMP) begin
      if (ovf_q)                   acc_next = acc_q;
      else if (ovf_dir == OVF_HIGH) acc_next = max_ext[ACC_WIDTH-1:0];
      else if (ovf_dir == OVF_LOW)  acc_next = min_ext[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_beats    <= '0;
    end else if (!stall) begin
      if (s1_valid && s1_last) begin
        out_valid    <= 1'b1;
        out_data     <= acc_next;
        out_overflow <= ovf_next;
        out_beats    <= cnt_next;
        acc_q        <= '0;
        ovf_q        <= 1'b0;
        cnt_q        <= '0;
      end else begin
        if (out_ready) out_valid <= 1'b0;
        if (s1_valid) begin
          acc_q <= acc_next;
          ovf_q <= ovf_next;
          cnt_q <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_accum.sv
// tb/tb_calc_accum.sv - directed and randomized checks of calc_accum against a behavioural model
module tb_calc_accum;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a_vec = '0;
  logic [31:0] b_vec = '0;
  bit          rnd_mode = 1'b0;

  always #5 clock = ~clock;

  logic        rdy0, rdy1, rdy2, rdy3;
  logic        ov0, ov1, ov2, ov3;
  logic        of0, of1, of2, of3;
  logic [31:0] od0, od1;
  logic [17:0] od2, od3;
  logic [15:0] ob0, ob1, ob2, ob3;

  calc_accum #(.SIGNED_MODE(0)) u0 (.clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .a_vec(a_vec), .b_vec(b_vec), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_overflow(of0), .out_beats(ob0));
  calc_accum #(.SIGNED_MODE(1)) u1 (.clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .a_vec(a_vec), .b_vec(b_vec), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_overflow(of1), .out_beats(ob1));
  calc_accum #(.ACC_WIDTH(18), .SATURATE(0)) u2 (.clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
    .a_vec(a_vec), .b_vec(b_vec), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .out_overflow(of2), .out_beats(ob2));
  calc_accum #(.ACC_WIDTH(18), .SATURATE(1)) u3 (.clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy3),
    .a_vec(a_vec), .b_vec(b_vec), .in_last(in_last), .out_valid(ov3), .out_ready(out_ready),
    .out_data(od3), .out_overflow(of3), .out_beats(ob3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: per-instance configuration and running packet state.
  int     sgn  [4] = '{0, 1, 0, 0};
  int     accw [4] = '{32, 32, 18, 18};
  int     sat  [4] = '{0, 0, 0, 1};
  longint macc [4];
  bit     movf [4];
  int     mbeats = 0;
  longint exp_d[$];
  bit     exp_o[$];
  int     exp_b[$];
  int     n_res = 0;
  longint last_d [4];
  bit     last_o [4];
  int     last_b = 0;

  function automatic longint beat_sum(input int k, input logic [31:0] a, input logic [31:0] b);
    longint s = 0;
    logic [7:0] ea, eb;
    for (int i = 0; i < 4; i++) begin
      ea = a[i*8 +: 8];
      eb = b[i*8 +: 8];
      if (sgn[k] != 0) s += longint'($signed(ea)) * longint'($signed(eb));
      else             s += longint'(ea) * longint'(eb);
    end
    return s;
  endfunction

  function automatic longint wrapv(input longint t, input int w, input bit s);
    longint one = 1;
    longint m;
    m = t & ((one <<< w) - 1);
    if (s && m >= (one <<< (w - 1))) m = m - (one <<< w);
    return m;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      macc[k] = 0;
      movf[k] = 1'b0;
    end
    mbeats = 0;
  endtask

  task automatic model_accept(input logic [31:0] a, input logic [31:0] b, input logic last);
    longint one = 1;
    longint hi, lo, t;
    for (int k = 0; k < 4; k++) begin
      hi = (sgn[k] != 0) ? (one <<< (accw[k] - 1)) - 1 : (one <<< accw[k]) - 1;
      lo = (sgn[k] != 0) ? -(one <<< (accw[k] - 1)) : 0;
      if (!(sat[k] != 0 && movf[k])) begin
        t = macc[k] + beat_sum(k, a, b);
        if (t > hi || t < lo) begin
          movf[k] = 1'b1;
          if (sat[k] != 0) macc[k] = (t > hi) ? hi : lo;
          else             macc[k] = wrapv(t, accw[k], sgn[k] != 0);
        end else begin
          macc[k] = t;
        end
      end
    end
    if (mbeats < 65535) mbeats++;
    if (last) begin
      for (int k = 0; k < 4; k++) begin
        exp_d.push_back(macc[k]);
        exp_o.push_back(movf[k]);
      end
      exp_b.push_back(mbeats);
      model_clear();
    end
  endtask

  // Single compare process: lockstep, hold stability, and every consumed result.
  bit     prev_hold = 1'b0;
  longint pd [4];
  bit     po [4];
  int     pb = 0;

  always @(negedge clock) begin
    longint gd [4];
    bit     go [4];
    gd[0] = longint'(od0);
    gd[1] = longint'($signed(od1));
    gd[2] = longint'(od2);
    gd[3] = longint'(od3);
    go    = '{of0, of1, of2, of3};
    if (reset) begin
      chk("in_ready_in_reset", rdy0, 0);
      model_clear();
      exp_d.delete();
      exp_o.delete();
      exp_b.delete();
      prev_hold = 1'b0;
    end else begin
      chk("lockstep_ready", {rdy1, rdy2, rdy3}, {rdy0, rdy0, rdy0});
      chk("lockstep_valid", {ov1, ov2, ov3}, {ov0, ov0, ov0});
      if (prev_hold) begin
        chk("hold_valid", ov0, 1);
        chk("hold_beats", ob0, pb);
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("hold_data_u%0d", k), gd[k], pd[k]);
          chk($sformatf("hold_ovf_u%0d", k), go[k], po[k]);
        end
      end
      if (ov0 && out_ready) begin
        if (exp_b.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got out_valid=1 data=%0d expected no result", gd[0]);
        end else begin
          last_b = exp_b.pop_front();
          chk("beats_u0", ob0, last_b);
          chk("beats_lockstep", {ob1, ob2, ob3}, {ob0, ob0, ob0});
          for (int k = 0; k < 4; k++) begin
            last_d[k] = exp_d.pop_front();
            last_o[k] = exp_o.pop_front();
            chk($sformatf("data_u%0d", k), gd[k], last_d[k]);
            chk($sformatf("ovf_u%0d", k), go[k], last_o[k]);
          end
          n_res++;
        end
      end
      if (in_valid && rdy0) model_accept(a_vec, b_vec, in_last);
      prev_hold = ov0 && !out_ready;
      pd = gd;
      po = go;
      pb = int'(ob0);
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (rnd_mode) out_ready = ($urandom_range(0, 9) < 7);
  end

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    a_vec    = a;
    b_vec    = b;
    in_last  = last;
    @(negedge clock);
    while (!rdy0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("send_accept", rdy0, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int target);
    int n = 0;
    while (n_res < target && n < 200) begin
      @(posedge clock);
      n++;
    end
    chk("result_arrived", (n_res >= target), 1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clock);
    chk("reset_in_ready", rdy0, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rel_in_ready", rdy0, 1);
    chk("rel_out_valid", ov0, 0);
    chk("rel_out_data", od0, 0);
    chk("rel_out_beats", ob0, 0);
    chk("rel_out_ovf", of3, 0);
    @(posedge clock);
    #1;

    // {1,2,3,4}.{5,6,7,8} = 70, two cycles after acceptance
    base = n_res;
    send_beat(32'h04030201, 32'h08070605, 1'b1);
    @(negedge clock);
    chk("lat_cycle1_valid", ov0, 0);
    @(negedge clock);
    chk("lat_cycle2_valid", ov0, 1);
    chk("dot_70", od0, 70);
    chk("dot_70_beats", ob0, 1);
    wait_res(base + 1);

    base = n_res;
    send_beat(32'h01010101, 32'h02020202, 1'b0);
    send_beat(32'h03030303, 32'h01010101, 1'b1);
    wait_res(base + 1);
    chk("two_beat_20", last_d[0], 20);
    chk("two_beat_cnt", last_b, 2);
    chk("two_beat_ovf", last_o[0], 0);

    base = n_res;
    send_beat(32'h0403FEFF, 32'h08F90605, 1'b1);
    wait_res(base + 1);
    chk("signed_minus6", last_d[1], -6);

    base = n_res;
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_res(base + 1);
    chk("acc18_one_beat", last_d[2], 260100);
    chk("acc18_one_ovf", last_o[2], 0);
    base = n_res;
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_res(base + 1);
    chk("acc32_two_beat", last_d[0], 520200);
    chk("acc18_wrap", last_d[2], 258056);
    chk("acc18_wrap_ovf", last_o[2], 1);
    chk("acc18_sat", last_d[3], 262143);
    chk("acc18_sat_ovf", last_o[3], 1);

    // Output held back while the next last beat waits in the pipe
    base = n_res;
    out_ready = 1'b0;
    send_beat(32'h04030201, 32'h08070605, 1'b1);
    send_beat(32'h01010101, 32'h02020202, 1'b1);
    repeat (5) begin
      @(negedge clock);
      chk("stall_in_ready", rdy0, 0);
      chk("stall_valid", ov0, 1);
      chk("stall_data", od0, 70);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(negedge clock);
    chk("release_data", od0, 70);
    @(negedge clock);
    chk("next_valid", ov0, 1);
    chk("next_data", od0, 8);
    wait_res(base + 2);

    // Reset after the first of three beats drops that packet entirely
    base = n_res;
    send_beat(32'h05050505, 32'h05050505, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    send_beat(32'h04030201, 32'h08070605, 1'b1);
    wait_res(base + 1);
    repeat (4) @(posedge clock);
    chk("post_reset_results", n_res, base + 1);
    chk("post_reset_data", last_d[0], 70);
    chk("post_reset_beats", last_b, 1);

    rnd_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        in_valid = 1'b0;
        a_vec    = $urandom;
        b_vec    = $urandom;
        in_last  = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
      end
      send_beat($urandom, $urandom, ($urandom_range(0, 3) == 0) || (n == 399));
    end
    rnd_mode  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clock);
    chk("drain_empty", exp_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_accum.md
CALC_ACCUM -- requirements
Module: calc_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width of A/B operands.
REQ-002 SHALL have parameter BLOCK_SIZE, default 4, elements per beat (>=1).
REQ-003 SHALL have parameter ACC_WIDTH, default 32, accumulator/result width (>= 2*DATA_WIDTH+clog2(BLOCK_SIZE)).
REQ-004 SHALL have parameter SIGNED_MODE, default 0, 1 = two's-complement operands, 0 = unsigned.
REQ-005 SHALL have parameter SATURATE, default 0, 1 = clamp on overflow, 0 = wrap.
REQ-006 SHALL have parameter CNT_WIDTH, default 16, width of beat counter.
REQ-007 clock  input  1  sole clock, rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 in_valid  input  1  beat present on a_vec/b_vec/in_last.
REQ-010 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-011 a_vec  input  DATA_WIDTH*BLOCK_SIZE  packed A elements, element i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 b_vec  input  DATA_WIDTH*BLOCK_SIZE  packed B elements, same packing.
REQ-013 in_last  input  1  final beat of current dot product.
REQ-014 out_valid  output  1  result held on out_data.
REQ-015 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-016 out_data  output  ACC_WIDTH  accumulated dot product.
REQ-017 out_overflow  output  1  result overflowed ACC_WIDTH at any beat.
REQ-018 out_beats  output  CNT_WIDTH  beats accumulated into out_data (saturates at all-ones).

Function
REQ-019 SHALL compute per beat S = sum over i of A[i]*B[i], full-precision, signedness per SIGNED_MODE.
REQ-020 SHALL pipeline as two stages: stage 1 registers BLOCK_SIZE products; stage 2 adds tree sum to accumulator.
REQ-021 SHALL present out_valid exactly 2 cycles after acceptance of the in_last beat when no stall occurs.
REQ-022 SHALL accumulate S across beats until in_last, then transfer total to output register and clear accumulator, count and overflow in same cycle.
REQ-023 SHALL stall whole pipeline (all stage registers hold) when out_valid && !out_ready && stage 2 holds a last beat; in_ready = !stall.
REQ-024 SHALL keep out_data, out_overflow, out_beats stable while out_valid && !out_ready.
REQ-025 SHALL accept a new last beat into stage 2 in the cycle the prior result is consumed (zero-bubble back-to-back results).
REQ-026 SHALL set overflow when true sum exceeds ACC_WIDTH range (unsigned: > 2^ACC_WIDTH-1; signed: outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]); flag sticky until result transfer.
REQ-027 SHALL, with SATURATE=1, clamp accumulator to range limit of overflow direction and hold it for remainder of packet; SATURATE=0 wraps modulo 2^ACC_WIDTH.
REQ-028 SHALL treat a single beat with in_last=1 as a complete 1-beat dot product.
REQ-029 SHALL ignore a_vec/b_vec/in_last when in_valid=0; bubbles do not alter accumulator.

Reset
REQ-030 SHALL on reset clear out_valid, out_data, out_overflow, out_beats, accumulator, stage valid bits to 0 at next rising edge.
REQ-031 SHALL drive in_ready=0 while reset is high and 1 in the first cycle after release.
REQ-032 SHALL discard any partial packet and pending result on reset mid-operation; no output produced for it.

Structure
REQ-033 SHALL place signedness/saturation mode constants and a clamp/width helper function in shared package calc_pkg.
REQ-034 SHALL implement stage 1 product and adder tree as sub-module calc_dot_tree (parameters DATA_WIDTH, BLOCK_SIZE, SIGNED_MODE).
REQ-035 SHALL hold RTL within 120-400 lines total.

Verification (DATA_WIDTH=8, BLOCK_SIZE=4 unless stated)
REQ-036 Unsigned A={1,2,3,4}, B={5,6,7,8}, in_last=1, out_ready=1 -> out_data=70, out_beats=1, out_valid 2 cycles after accept.
REQ-037 Two beats A={1,1,1,1},B={2,2,2,2} then A={3,3,3,3},B={1,1,1,1} last -> out_data=20, out_beats=2, overflow=0.
REQ-038 SIGNED_MODE=1, A={-1,-2,3,4}, B={5,6,-7,8} -> out_data=-6 (32'hFFFFFFFA).
REQ-039 ACC_WIDTH=18, all elements 255, 1 beat -> true 260100; SATURATE=0: 260100 mod 2^18=260100 no overflow; 2 beats -> 520200, wrap gives 258056, overflow=1; SATURATE=1 gives 262143, overflow=1.
REQ-040 Result pending, out_ready=0 for 5 cycles, next packet's last beat in flight -> in_ready=0, out_data stable; out_ready=1 -> next result follows next cycle.
REQ-041 Reset asserted after 1 of 3 beats, then fresh 1-beat packet {1,2,3,4}·{5,6,7,8} -> only out_data=70, out_beats=1 observed.
